fetch_sequencer: RTL and testbench

//  Sequences instruction fetch between the PC and instruction memory: owns the fetch PC,

---
 rtl/fetch_sequencer_if.sv | 47 ++++
 rtl/fetch_sequencer.sv | 143 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction-memory request/response channel plus the
// decoded-instruction output buffer handshake.
//
// Handshake rules:
//   imem request : the address is accepted in a cycle where imem_req_o and imem_gnt_i
//                  are both high; exactly one imem_rvalid_i pulse follows, at least one
//                  cycle later.
//   inst output  : the instruction moves to decode in a cycle where inst_valid_o and
//                  inst_ready_i are both high; inst_o/inst_pc_o hold while valid & !ready.
interface fetch_sequencer_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          imem_req_o;
    logic [AW-1:0] imem_addr_o;
    logic          imem_gnt_i;
    logic          imem_rvalid_i;
    logic [DW-1:0] imem_rdata_i;
    logic          inst_valid_o;
    logic [DW-1:0] inst_o;
    logic [AW-1:0] inst_pc_o;
    logic          inst_ready_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i,
        output inst_valid_o,
        output inst_o,
        output inst_pc_o,
        input  inst_ready_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i,
        input  inst_valid_o,
        input  inst_o,
        input  inst_pc_o,
        output inst_ready_i
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC, keeps one imem request in flight,
// buffers one instruction for decode and applies start/branch redirects with squash.
module fetch_sequencer #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [AW-1:0]         start_address_i,
    input  logic                  branch_i,
    input  logic [AW-1:0]         branchloc_i,
    output logic                  busy_o,
    output logic [1:0]            dbg_state_o,
    fetch_sequencer_if.master     bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_nxt;
    logic [AW-1:0] r_base_pc;
    logic [AW-1:0] w_base_pc_nxt;
    logic          r_squash;
    logic          w_squash_nxt;
    logic          r_inst_valid;
    logic          w_inst_valid_nxt;
    logic [DW-1:0] r_inst;
    logic [DW-1:0] w_inst_nxt;
    logic [AW-1:0] r_inst_pc;
    logic [AW-1:0] w_inst_pc_nxt;

    logic          w_hs;
    logic          w_req;
    logic          w_gnt;
    logic          w_branch;
    logic          w_redirect;
    logic [AW-1:0] w_base_eff;
    logic [AW-1:0] w_redirect_pc;

    assign w_hs       = r_inst_valid & bus.inst_ready_i;
    // A new fetch may only launch when the buffer will be free to take its result.
    assign w_req      = (r_state == ST_REQ) & (~r_inst_valid | bus.inst_ready_i);
    assign w_gnt      = w_req & bus.imem_gnt_i;
    assign w_branch   = branch_i & (r_state != ST_IDLE);
    assign w_redirect = start_i | w_branch;
    // Branch base must see an instruction handed to decode in this same cycle.
    assign w_base_eff    = w_hs ? r_inst_pc : r_base_pc;
    assign w_redirect_pc = start_i ? start_address_i : (w_base_eff + branchloc_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_pc         <= '0;
            r_base_pc    <= '0;
            r_squash     <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_base_pc    <= w_base_pc_nxt;
            r_squash     <= w_squash_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_pc    <= w_inst_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_base_pc_nxt    = w_base_eff;
        w_squash_nxt     = r_squash;
        w_inst_valid_nxt = r_inst_valid & ~w_hs;
        w_inst_nxt       = r_inst;
        w_inst_pc_nxt    = r_inst_pc;

        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_pc_nxt         = start_address_i;
                    w_inst_valid_nxt = 1'b0;
                    w_state_nxt      = ST_REQ;
                end
            end

            ST_REQ: begin
                if (w_gnt) begin
                    w_state_nxt = ST_WAIT;
                end
                if (w_redirect) begin
                    w_pc_nxt         = w_redirect_pc;
                    w_inst_valid_nxt = 1'b0;
                    // The request just granted fetches the old PC; its response is stale.
                    if (w_gnt) begin
                        w_squash_nxt = 1'b1;
                    end
                end
            end

            ST_WAIT: begin
                if (bus.imem_rvalid_i) begin
                    w_state_nxt  = ST_REQ;
                    w_squash_nxt = 1'b0;
                    if (w_redirect) begin
                        w_pc_nxt         = w_redirect_pc;
                        w_inst_valid_nxt = 1'b0;
                    end else if (!r_squash) begin
                        w_inst_nxt       = bus.imem_rdata_i;
                        w_inst_pc_nxt    = r_pc;
                        w_inst_valid_nxt = 1'b1;
                        w_pc_nxt         = r_pc + AW'(1);
                    end
                end else if (w_redirect) begin
                    w_pc_nxt         = w_redirect_pc;
                    w_inst_valid_nxt = 1'b0;
                    w_squash_nxt     = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.imem_req_o   = w_req;
    assign bus.imem_addr_o  = r_pc;
    assign bus.inst_valid_o = r_inst_valid;
    assign bus.inst_o       = r_inst;
    assign bus.inst_pc_o    = r_inst_pc;
    assign busy_o           = (r_state != ST_IDLE);
    assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: memory responder model, scoreboard queues for
// fetch addresses and delivered instructions, and direct checks of latency/stall/reset.
module tb_fetch_sequencer;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i;
    logic [AW-1:0] start_address_i;
    logic          branch_i;
    logic [AW-1:0] branchloc_i;
    logic          busy_o;
    logic [1:0]    dbg_state_o;

    fetch_sequencer_if #(.AW(AW), .DW(DW)) bus ();

    fetch_sequencer #(.AW(AW), .DW(DW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .start_address_i (start_address_i),
        .branch_i        (branch_i),
        .branchloc_i     (branchloc_i),
        .busy_o          (busy_o),
        .dbg_state_o     (dbg_state_o),
        .bus             (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [AW-1:0]    exp_addr_q[$];
    logic [AW+DW-1:0] exp_inst_q[$];

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {~a, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_addr(input logic [AW-1:0] a);
        exp_addr_q.push_back(a);
    endtask

    task automatic push_inst(input logic [AW-1:0] pc);
        exp_inst_q.push_back({pc, mem_word(pc)});
    endtask

    // ---------------- memory responder ----------------
    int            mem_lat = 1;
    logic          m_fire;
    logic [AW-1:0] m_fa;
    logic          m_pend = 1'b0;
    logic [AW-1:0] m_addr;
    int            m_cnt;

    always @(posedge clk) begin
        m_fire = bus.imem_req_o & bus.imem_gnt_i;
        m_fa   = bus.imem_addr_o;
        #1;
        bus.imem_rvalid_i = 1'b0;
        if (!rst_n) begin
            m_pend = 1'b0;
            bus.imem_rdata_i = '0;
        end else begin
            if (m_fire) begin
                m_pend = 1'b1;
                m_addr = m_fa;
                m_cnt  = mem_lat - 1;
            end
            if (m_pend) begin
                if (m_cnt == 0) begin
                    bus.imem_rvalid_i = 1'b1;
                    bus.imem_rdata_i  = mem_word(m_addr);
                    m_pend = 1'b0;
                end else begin
                    m_cnt--;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.imem_req_o && bus.imem_gnt_i) begin
                if (exp_addr_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL fetch_addr: unexpected fetch of %0h, none expected", bus.imem_addr_o);
                end else begin
                    check("fetch_addr", bus.imem_addr_o, exp_addr_q.pop_front());
                end
            end
            if (bus.inst_valid_o && bus.inst_ready_i) begin
                if (exp_inst_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL inst_out: unexpected inst pc %0h, none expected", bus.inst_pc_o);
                end else begin
                    check("inst_out", {bus.inst_pc_o, bus.inst_o}, exp_inst_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input logic [AW-1:0] a);
        start_i = 1'b1;
        start_address_i = a;
        tick(1);
        start_i = 1'b0;
    endtask

    task automatic take();
        bus.inst_ready_i = 1'b1;
        tick(1);
        bus.inst_ready_i = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k = 0;
        while (!bus.inst_valid_o && k < budget) begin
            tick(1);
            k++;
        end
        check(name, bus.inst_valid_o, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        start_i          = 1'b0;
        start_address_i  = '0;
        branch_i         = 1'b0;
        branchloc_i      = '0;
        bus.imem_gnt_i   = 1'b1;
        bus.inst_ready_i = 1'b0;

        // reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_req", bus.imem_req_o, 0);
        check("rst_addr", bus.imem_addr_o, 0);
        check("rst_valid", bus.inst_valid_o, 0);
        check("rst_inst", {bus.inst_pc_o, bus.inst_o}, 0);
        check("rst_busy", {busy_o, dbg_state_o}, 0);
        rst_n = 1'b1;
        tick(2);
        check("idle_no_req", bus.imem_req_o, 0);

        // sequential fetch from 10h, exact latencies, then stall
        mem_lat = 1;
        push_addr(8'h10); push_addr(8'h11); push_addr(8'h12); push_addr(8'h13);
        push_inst(8'h10); push_inst(8'h11); push_inst(8'h12);
        start_i = 1'b1;
        start_address_i = 8'h10;
        tick(1);
        start_i = 1'b0;
        check("start_latency_req", {bus.imem_req_o, bus.imem_addr_o}, {1'b1, 8'h10});
        check("start_busy", busy_o, 1);
        tick(1);
        check("valid_before_rvalid", bus.inst_valid_o, 0);
        tick(1);
        check("valid_after_rvalid", {bus.inst_valid_o, bus.inst_pc_o}, {1'b1, 8'h10});
        for (int i = 0; i < 4; i++) begin
            check("stall_hold", {bus.imem_req_o, bus.inst_pc_o, bus.inst_o}, {1'b0, 8'h10, 16'hEF10});
            tick(1);
        end
        take();
        wait_valid("seq_valid_11", 20);
        take();
        wait_valid("seq_valid_12", 20);
        take();
        wait_valid("seq_valid_13", 20);
        check("seq_pc_13", bus.inst_pc_o, 8'h13);

        // branch relative to handshaken 20h while waiting: stale response dropped
        push_addr(8'h20);
        pulse_start(8'h20);
        wait_valid("br_valid_20", 20);
        mem_lat = 3;
        push_inst(8'h20);
        push_addr(8'h21);
        push_addr(8'h25);
        take();
        branch_i = 1'b1;
        branchloc_i = 8'h05;
        tick(1);
        branch_i = 1'b0;
        check("br_valid_cleared", {bus.inst_valid_o, busy_o}, {1'b0, 1'b1});
        wait_valid("br_valid_25", 30);
        check("br_pc_25", {bus.inst_pc_o, bus.inst_o}, {8'h25, 16'hDA25});
        push_inst(8'h25);
        push_addr(8'h26);
        take();
        wait_valid("br_valid_26", 30);

        // start and branch together: start wins
        push_addr(8'h40);
        start_i = 1'b1;
        start_address_i = 8'h40;
        branch_i = 1'b1;
        branchloc_i = 8'h07;
        tick(1);
        start_i = 1'b0;
        branch_i = 1'b0;
        check("start_over_branch", {bus.imem_req_o, bus.imem_addr_o}, {1'b1, 8'h40});
        wait_valid("start_valid_40", 30);
        check("start_pc_40", bus.inst_pc_o, 8'h40);
        mem_lat = 1;
        push_inst(8'h40);
        push_addr(8'h41);
        take();
        wait_valid("start_valid_41", 20);

        // PC wrap FEh -> 01h
        push_addr(8'hFE); push_addr(8'hFF); push_addr(8'h00); push_addr(8'h01);
        push_inst(8'hFE); push_inst(8'hFF); push_inst(8'h00);
        pulse_start(8'hFE);
        wait_valid("wrap_valid_fe", 20);
        take();
        wait_valid("wrap_valid_ff", 20);
        take();
        wait_valid("wrap_valid_00", 20);
        take();
        wait_valid("wrap_valid_01", 20);
        check("wrap_pc_01", bus.inst_pc_o, 8'h01);

        // branch from base F0h + 20h wraps to 10h, arriving with the rvalid of F1h
        push_addr(8'hF0);
        pulse_start(8'hF0);
        wait_valid("wbr_valid_f0", 20);
        push_inst(8'hF0);
        push_addr(8'hF1);
        push_addr(8'h10);
        take();
        branch_i = 1'b1;
        branchloc_i = 8'h20;
        tick(1);
        branch_i = 1'b0;
        wait_valid("wbr_valid_10", 20);
        check("wbr_pc_10", {bus.inst_pc_o, bus.inst_o}, {8'h10, 16'hEF10});

        // branch during handshake + grant: base is the handed-off 10h, fetch of 11h squashed
        push_inst(8'h10);
        push_addr(8'h11);
        push_addr(8'h13);
        bus.inst_ready_i = 1'b1;
        branch_i = 1'b1;
        branchloc_i = 8'h03;
        tick(1);
        bus.inst_ready_i = 1'b0;
        branch_i = 1'b0;
        check("hsbr_squash_wait", {bus.inst_valid_o, dbg_state_o}, {1'b0, 2'd2});
        wait_valid("hsbr_valid_13", 20);
        check("hsbr_pc_13", {bus.inst_pc_o, bus.inst_o}, {8'h13, 16'hEC13});

        // asynchronous reset with a buffered instruction
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_outs", {bus.inst_valid_o, bus.imem_req_o, busy_o, dbg_state_o}, 0);
        check("async_rst_data", {bus.inst_pc_o, bus.inst_o, bus.imem_addr_o}, 0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check("post_rst_idle", {bus.imem_req_o, busy_o}, 0);
        push_addr(8'h50);
        pulse_start(8'h50);
        wait_valid("post_rst_valid_50", 20);
        check("post_rst_pc_50", bus.inst_pc_o, 8'h50);
        push_inst(8'h50);
        push_addr(8'h51);
        take();
        tick(4);

        check("addr_q_drained", exp_addr_q.size(), 0);
        check("inst_q_drained", exp_inst_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
